// File: rtl/soc_system_clkgen_n_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// soc_system_clkgen_n_if : configuration write/apply bundle for the clkgen.
// Rev 1.0
// ----------------------------------------------------------------------------
interface soc_system_clkgen_n_if #(
  parameter int CHW   = 1,
  parameter int CNT_W = 9
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CHW-1:0]   cfg_chan;
  logic [CNT_W-1:0] cfg_hi;
  logic [CNT_W-1:0] cfg_lo;
  logic [CNT_W-1:0] cfg_prst;
  logic             cfg_bypass;
  logic             cfg_apply;
  logic             cfg_err;

  modport master (
    output cfg_valid, cfg_chan, cfg_hi, cfg_lo, cfg_prst, cfg_bypass, cfg_apply,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_chan, cfg_hi, cfg_lo, cfg_prst, cfg_bypass, cfg_apply,
    output cfg_ready, cfg_err
  );
endinterface
`default_nettype wire

// File: rtl/soc_system_clkgen_n.sv
`default_nettype none
// ----------------------------------------------------------------------------
// soc_system_clkgen_n : N-channel runtime-programmable clock-enable generator.
// Rev 1.0
// ----------------------------------------------------------------------------
module soc_system_clkgen_n #(
  parameter int NUM_CLOCKS  = 2,
  parameter int CNT_W       = 9,
  parameter int LOCK_CYCLES = 16,
  parameter logic [NUM_CLOCKS*CNT_W-1:0] INIT_HI   = {9'd12, 9'd6},
  parameter logic [NUM_CLOCKS*CNT_W-1:0] INIT_LO   = {9'd12, 9'd6},
  parameter logic [NUM_CLOCKS*CNT_W-1:0] INIT_PRST = '0
) (
  input  wire logic                  refclk,
  input  wire logic                  rst,
  output logic [NUM_CLOCKS-1:0]      outclk_en,
  output logic [NUM_CLOCKS-1:0]      outclk_lvl,
  output logic                       locked,
  soc_system_clkgen_n_if.slave       cfg
);

  localparam int CHW = $clog2((NUM_CLOCKS > 2) ? NUM_CLOCKS : 2);
  localparam int LCW = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_RUN    = 2'd1,
    ST_RELOCK = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nx;
  logic [LCW-1:0] r_lock_cnt;
  logic           w_lock_done;
  logic           w_wr;
  logic           w_bad;
  logic           w_apply;
  logic           w_run_nx;
  logic           w_run_entry;
  logic           r_locked;
  logic           r_err;

  assign w_lock_done   = (r_lock_cnt == LCW'(LOCK_CYCLES - 1));
  assign cfg.cfg_ready = ~rst & (r_state != ST_RELOCK);
  assign w_wr          = cfg.cfg_valid & cfg.cfg_ready;
  assign w_apply       = (r_state == ST_RUN) & cfg.cfg_apply;
  assign w_run_nx      = (w_state_nx == ST_RUN);
  assign w_run_entry   = w_run_nx & (r_state != ST_RUN);
  assign locked        = r_locked;
  assign cfg.cfg_err   = r_err;

  // Only a non-power-of-two channel count leaves unused cfg_chan codes.
  if ((1 << CHW) > NUM_CLOCKS) begin : g_chan_chk
    assign w_bad = (cfg.cfg_chan >= CHW'(NUM_CLOCKS));
  end else begin : g_chan_nochk
    assign w_bad = 1'b0;
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      r_state <= ST_SETTLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_SETTLE: if (w_lock_done) w_state_nx = ST_RUN;
      ST_RUN:    if (cfg.cfg_apply) w_state_nx = ST_RELOCK;
      ST_RELOCK: if (w_lock_done) w_state_nx = ST_RUN;
      default:   w_state_nx = ST_SETTLE;
    endcase
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      r_lock_cnt <= '0;
      r_locked   <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_lock_cnt <= (r_state == ST_RUN || w_lock_done) ? '0 : r_lock_cnt + LCW'(1);
      r_locked   <= w_run_nx;
      r_err      <= w_wr & w_bad;
    end
  end

  for (genvar i = 0; i < NUM_CLOCKS; i++) begin : g_ch
    logic [CNT_W-1:0] r_sh_hi, r_sh_lo, r_sh_prst;
    logic [CNT_W-1:0] r_act_hi, r_act_lo, r_act_prst;
    logic             r_sh_byp, r_act_byp;
    logic [CNT_W-1:0] r_dly, w_dly_nx;
    logic [CNT_W:0]   r_ph, w_ph_nx;
    logic [CNT_W:0]   w_h, w_l, w_per;
    logic             w_sel;
    logic             w_en_nx, w_lvl_nx;
    logic             r_en, r_lvl;

    assign w_sel = w_wr & ~w_bad & (cfg.cfg_chan == CHW'(i));
    assign w_h   = (r_act_hi == '0) ? (CNT_W+1)'(1) : {1'b0, r_act_hi};
    assign w_l   = (r_act_lo == '0) ? (CNT_W+1)'(1) : {1'b0, r_act_lo};
    assign w_per = w_h + w_l;

    // Counters describe the upcoming cycle so the outputs can be registered.
    always_comb begin
      w_dly_nx = r_dly;
      w_ph_nx  = r_ph;
      if (w_run_entry) begin
        w_dly_nx = r_act_prst;
        w_ph_nx  = '0;
      end else if (r_state == ST_RUN) begin
        if (r_dly != '0) begin
          w_dly_nx = r_dly - CNT_W'(1);
          w_ph_nx  = '0;
        end else if (r_ph == w_per - (CNT_W+1)'(1)) begin
          w_ph_nx  = '0;
        end else begin
          w_ph_nx  = r_ph + (CNT_W+1)'(1);
        end
      end
      w_en_nx  = w_run_nx & (r_act_byp | ((w_dly_nx == '0) & (w_ph_nx == '0)));
      w_lvl_nx = w_run_nx & (r_act_byp | ((w_dly_nx == '0) & (w_ph_nx < w_h)));
    end

    always_ff @(posedge refclk) begin
      if (rst) begin
        r_sh_hi    <= INIT_HI[i*CNT_W +: CNT_W];
        r_sh_lo    <= INIT_LO[i*CNT_W +: CNT_W];
        r_sh_prst  <= INIT_PRST[i*CNT_W +: CNT_W];
        r_sh_byp   <= 1'b0;
        r_act_hi   <= INIT_HI[i*CNT_W +: CNT_W];
        r_act_lo   <= INIT_LO[i*CNT_W +: CNT_W];
        r_act_prst <= INIT_PRST[i*CNT_W +: CNT_W];
        r_act_byp  <= 1'b0;
        r_dly      <= '0;
        r_ph       <= '0;
        r_en       <= 1'b0;
        r_lvl      <= 1'b0;
      end else begin
        if (w_sel) begin
          r_sh_hi   <= cfg.cfg_hi;
          r_sh_lo   <= cfg.cfg_lo;
          r_sh_prst <= cfg.cfg_prst;
          r_sh_byp  <= cfg.cfg_bypass;
        end
        // A write in the apply cycle is forwarded straight into the active set.
        if (w_apply) begin
          r_act_hi   <= w_sel ? cfg.cfg_hi     : r_sh_hi;
          r_act_lo   <= w_sel ? cfg.cfg_lo     : r_sh_lo;
          r_act_prst <= w_sel ? cfg.cfg_prst   : r_sh_prst;
          r_act_byp  <= w_sel ? cfg.cfg_bypass : r_sh_byp;
        end
        r_dly <= w_dly_nx;
        r_ph  <= w_ph_nx;
        r_en  <= w_en_nx;
        r_lvl <= w_lvl_nx;
      end
    end

    assign outclk_en[i]  = r_en;
    assign outclk_lvl[i] = r_lvl;
  end

endmodule
`default_nettype wire

// File: tb/tb_soc_system_clkgen_n.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_soc_system_clkgen_n : directed table-driven bench for the clkgen (3 ch).
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_soc_system_clkgen_n;

  localparam int NCH = 3;
  localparam int CW  = 9;

  logic           refclk;
  logic           rst;
  logic [NCH-1:0] outclk_en;
  logic [NCH-1:0] outclk_lvl;
  logic           locked;

  soc_system_clkgen_n_if #(.CHW(2), .CNT_W(CW)) cfg_if ();

  soc_system_clkgen_n #(
    .NUM_CLOCKS (NCH),
    .CNT_W      (CW),
    .LOCK_CYCLES(16),
    .INIT_HI    ({9'd4, 9'd12, 9'd6}),
    .INIT_LO    ({9'd4, 9'd12, 9'd6}),
    .INIT_PRST  ('0)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .outclk_en (outclk_en),
    .outclk_lvl(outclk_lvl),
    .locked    (locked),
    .cfg       (cfg_if.slave)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  typedef struct packed {
    logic [2:0][9:0] per;
    logic [2:0][9:0] hi;
    logic [2:0][9:0] first;
    logic [2:0]      byp;
  } exp_t;

  typedef struct {
    bit   wr;
    int   chan;
    int   hi;
    int   lo;
    int   prst;
    bit   byp;
    exp_t e;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  vec_t tbl[5];
  exp_t e_init;
  exp_t e_cur;
  exp_t e_wa;
  int   n;

  function automatic exp_t mk(input int p2, p1, p0, h2, h1, h0, f2, f1, f0,
                              input logic [2:0] b);
    exp_t e;
    e.per   = {10'(p2), 10'(p1), 10'(p0)};
    e.hi    = {10'(h2), 10'(h1), 10'(h0)};
    e.first = {10'(f2), 10'(f1), 10'(f0)};
    e.byp   = b;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic wait_lock(output int cnt);
    cnt = 41;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (locked) begin
        cnt = i;
        break;
      end
    end
  endtask

  task automatic cfg_write(input int ch, hi, lo, prst, input bit byp, input bit apply);
    cfg_if.cfg_valid  = 1'b1;
    cfg_if.cfg_chan   = 2'(ch);
    cfg_if.cfg_hi     = 9'(hi);
    cfg_if.cfg_lo     = 9'(lo);
    cfg_if.cfg_prst   = 9'(prst);
    cfg_if.cfg_bypass = byp;
    cfg_if.cfg_apply  = apply;
    chk("wr_ready", 32'(cfg_if.cfg_ready), 32'd1);
    tick();
    cfg_if.cfg_valid  = 1'b0;
    cfg_if.cfg_apply  = 1'b0;
  endtask

  task automatic do_apply();
    cfg_if.cfg_apply = 1'b1;
    tick();
    cfg_if.cfg_apply = 1'b0;
    chk("relock_locked", 32'(locked), 32'd0);
    chk("relock_ready", 32'(cfg_if.cfg_ready), 32'd0);
  endtask

  // Called on the first locked cycle; k counts RUN cycles from there.
  task automatic run_check(input exp_t e, input int ncyc, input string tag);
    logic [2:0] ee, el;
    int f, p, h, q;
    for (int k = 0; k < ncyc; k++) begin
      for (int c = 0; c < 3; c++) begin
        f = int'(e.first[c]);
        p = int'(e.per[c]);
        h = int'(e.hi[c]);
        if (e.byp[c]) begin
          ee[c] = 1'b1;
          el[c] = 1'b1;
        end else if (k < f) begin
          ee[c] = 1'b0;
          el[c] = 1'b0;
        end else begin
          q     = (k - f) % p;
          ee[c] = (q == 0);
          el[c] = (q < h);
        end
      end
      chk({tag, "_en"}, 32'(outclk_en), 32'(ee));
      chk({tag, "_lvl"}, 32'(outclk_lvl), 32'(el));
      tick();
    end
  endtask

  initial begin
    e_init = mk(8, 24, 12,  4, 12, 6,  0, 0, 0, 3'b000);
    tbl[0] = '{wr: 1'b0, chan: 0, hi: 0, lo: 0, prst: 0, byp: 1'b0, e: e_init};
    tbl[1] = '{wr: 1'b1, chan: 0, hi: 2, lo: 3, prst: 0, byp: 1'b0,
               e: mk(8, 24, 5,  4, 12, 2,  0, 0, 0, 3'b000)};
    tbl[2] = '{wr: 1'b1, chan: 1, hi: 12, lo: 12, prst: 4, byp: 1'b0,
               e: mk(8, 24, 5,  4, 12, 2,  0, 4, 0, 3'b000)};
    tbl[3] = '{wr: 1'b1, chan: 0, hi: 2, lo: 3, prst: 0, byp: 1'b1,
               e: mk(8, 24, 5,  4, 12, 2,  0, 4, 0, 3'b001)};
    tbl[4] = '{wr: 1'b1, chan: 1, hi: 0, lo: 0, prst: 0, byp: 1'b0,
               e: mk(8, 2, 5,  4, 1, 2,  0, 0, 0, 3'b001)};
    e_wa   = mk(3, 2, 5,  1, 1, 2,  0, 0, 0, 3'b001);

    rst = 1'b1;
    cfg_if.cfg_valid  = 1'b0;
    cfg_if.cfg_chan   = '0;
    cfg_if.cfg_hi     = '0;
    cfg_if.cfg_lo     = '0;
    cfg_if.cfg_prst   = '0;
    cfg_if.cfg_bypass = 1'b0;
    cfg_if.cfg_apply  = 1'b0;
    repeat (3) tick();
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_en", 32'(outclk_en), 32'd0);
    chk("rst_lvl", 32'(outclk_lvl), 32'd0);
    chk("rst_ready", 32'(cfg_if.cfg_ready), 32'd0);
    chk("rst_err", 32'(cfg_if.cfg_err), 32'd0);
    rst = 1'b0;
    #1;
    chk("settle_ready", 32'(cfg_if.cfg_ready), 32'd1);

    // Scenario table: optional write, apply, relock, then waveform check.
    for (int s = 0; s < 5; s++) begin
      if (s != 0) begin
        if (tbl[s].wr)
          cfg_write(tbl[s].chan, tbl[s].hi, tbl[s].lo, tbl[s].prst, tbl[s].byp, 1'b0);
        do_apply();
      end
      wait_lock(n);
      chk($sformatf("lock_len_s%0d", s), 32'(n), 32'd16);
      run_check(tbl[s].e, 30, $sformatf("s%0d", s));
    end
    e_cur = tbl[4].e;

    // Out-of-range channel: accepted, error pulse, nothing staged.
    chk("err_idle", 32'(cfg_if.cfg_err), 32'd0);
    cfg_write(3, 1, 1, 0, 1'b0, 1'b0);
    chk("err_pulse", 32'(cfg_if.cfg_err), 32'd1);
    tick();
    chk("err_clear", 32'(cfg_if.cfg_err), 32'd0);
    do_apply();
    wait_lock(n);
    chk("lock_len_err", 32'(n), 32'd16);
    run_check(e_cur, 20, "err_nochg");

    // Write attempt during RELOCK must be refused.
    do_apply();
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_chan  = 2'd0;
    cfg_if.cfg_hi    = 9'd1;
    cfg_if.cfg_lo    = 9'd1;
    cfg_if.cfg_bypass = 1'b0;
    chk("relock_wr_ready", 32'(cfg_if.cfg_ready), 32'd0);
    tick();
    cfg_if.cfg_valid = 1'b0;
    wait_lock(n);
    chk("lock_len_relockwr", 32'(n), 32'd15);
    do_apply();
    wait_lock(n);
    chk("lock_len_reapply", 32'(n), 32'd16);
    run_check(e_cur, 20, "relock_nochg");

    // Write and apply in the same cycle.
    cfg_write(2, 1, 2, 0, 1'b0, 1'b1);
    chk("wa_locked", 32'(locked), 32'd0);
    wait_lock(n);
    chk("lock_len_wa", 32'(n), 32'd16);
    run_check(e_wa, 20, "wa");

    // Reset in the middle of RELOCK discards the staged ch0 values.
    cfg_write(0, 2, 3, 0, 1'b0, 1'b0);
    do_apply();
    repeat (5) tick();
    chk("midrelock_locked", 32'(locked), 32'd0);
    rst = 1'b1;
    tick();
    chk("midrst_ready", 32'(cfg_if.cfg_ready), 32'd0);
    tick();
    chk("midrst_en", 32'(outclk_en), 32'd0);
    rst = 1'b0;
    wait_lock(n);
    chk("lock_len_midrst", 32'(n), 32'd16);
    run_check(e_init, 30, "midrst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
